// File: rtl/tag_array_arbiter.sv
// Single-owner lock and read/evaluate/write sequencer for the shared LLC tag array.
// Optional `STARVE_GUARD_EN: CPU is forced to win after STARVE_MAX consecutive losses.
module tag_array_arbiter #(
  parameter int SET_W      = 16,
  parameter int LINE_W     = 103,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic [SET_W-1:0]  cpu_set,
  input  logic              snp_req,
  input  logic [SET_W-1:0]  snp_set,
  input  logic              clr_req,
  output logic              cpu_gnt,
  output logic              snp_gnt,
  output logic [1:0]        owner,
  output logic              rd_valid,
  output logic [LINE_W-1:0] rd_data,
  input  logic              wb_valid,
  input  logic              wb_we,
  input  logic [LINE_W-1:0] wb_data,
  output logic              ram_en,
  output logic              ram_we,
  output logic [SET_W-1:0]  ram_addr,
  output logic [LINE_W-1:0] ram_wdata,
  input  logic [LINE_W-1:0] ram_rdata,
  output logic              clr_busy,
  output logic              clr_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_WAIT, S_HOLD, S_WB, S_CLR
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_SNP  = 2'd2,
    OWN_CLR  = 2'd3
  } owner_t;

  localparam logic [SET_W-1:0] LAST_SET = '1;

  state_t           state;
  owner_t           owner_q;
  logic             ram_en_q;
  logic             ram_we_q;
  logic [SET_W-1:0] clr_cnt;
  logic             starved;
  logic             win_clr;
  logic             win_snp;
  logic             win_cpu;

  assign owner  = owner_q;
  // Reset suppresses any access already registered for this cycle.
  assign ram_en = ram_en_q & ~rst;
  assign ram_we = ram_we_q & ~rst;

  // Fixed priority clr > snp > cpu, except a starved CPU overtakes the snoop path.
  // NOTE: every signal written in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    win_clr = clr_req;
    win_snp = !clr_req && snp_req && !(cpu_req && starved);
    win_cpu = !clr_req && cpu_req && (!snp_req || starved);
  end

`ifdef STARVE_GUARD_EN
  localparam int               CNT_W      = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt;

  assign starved = (starve_cnt == STARVE_LIM);

  // Saturating count of arbitrations the CPU lost while it was requesting.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (state == S_IDLE) begin
      if (win_cpu)
        starve_cnt <= '0;
      else if ((win_clr || win_snp) && cpu_req && !starved)
        starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  assign starved = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      owner_q   <= OWN_NONE;
      cpu_gnt   <= 1'b0;
      snp_gnt   <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      ram_en_q  <= 1'b0;
      ram_we_q  <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      clr_busy  <= 1'b0;
      clr_done  <= 1'b0;
      clr_cnt   <= '0;
    end else begin
      cpu_gnt  <= 1'b0;
      snp_gnt  <= 1'b0;
      rd_valid <= 1'b0;
      clr_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (win_clr) begin
            state     <= S_CLR;
            owner_q   <= OWN_CLR;
            ram_en_q  <= 1'b1;
            ram_we_q  <= 1'b1;
            ram_addr  <= clr_cnt;
            ram_wdata <= '0;
            clr_busy  <= 1'b1;
          end else if (win_snp) begin
            state    <= S_RD;
            owner_q  <= OWN_SNP;
            snp_gnt  <= 1'b1;
            ram_en_q <= 1'b1;
            ram_we_q <= 1'b0;
            ram_addr <= snp_set;
          end else if (win_cpu) begin
            state    <= S_RD;
            owner_q  <= OWN_CPU;
            cpu_gnt  <= 1'b1;
            ram_en_q <= 1'b1;
            ram_we_q <= 1'b0;
            ram_addr <= cpu_set;
          end
        end
        S_RD: begin
          state    <= S_WAIT;
          ram_en_q <= 1'b0;
        end
        S_WAIT: begin
          // The array read issued in RD is on ram_rdata now.
          state    <= S_HOLD;
          rd_valid <= 1'b1;
          rd_data  <= ram_rdata;
        end
        S_HOLD: begin
          if (wb_valid) begin
            state     <= S_WB;
            ram_en_q  <= wb_we;
            ram_we_q  <= wb_we;
            ram_wdata <= wb_data;
          end
        end
        S_WB: begin
          state    <= S_IDLE;
          owner_q  <= OWN_NONE;
          ram_en_q <= 1'b0;
          ram_we_q <= 1'b0;
        end
        S_CLR: begin
          if (clr_cnt == LAST_SET) begin
            state    <= S_IDLE;
            owner_q  <= OWN_NONE;
            ram_en_q <= 1'b0;
            ram_we_q <= 1'b0;
            clr_busy <= 1'b0;
            clr_done <= 1'b1;
            clr_cnt  <= '0;
          end else begin
            clr_cnt  <= clr_cnt + 1'b1;
            ram_addr <= clr_cnt + 1'b1;
          end
        end
        default: begin
          state    <= S_IDLE;
          owner_q  <= OWN_NONE;
          ram_en_q <= 1'b0;
          ram_we_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tag_array_arbiter.sv
// Self-checking bench for tag_array_arbiter: RAM model, shadow set image and arbitration rule model.
// Expectations follow `STARVE_GUARD_EN when the macro is defined for both files.
module tb_tag_array_arbiter;

  localparam int SET_W      = 4;
  localparam int LINE_W     = 103;
  localparam int STARVE_MAX = 4;
  localparam int NSETS      = 1 << SET_W;

  logic              clk;
  logic              rst;
  logic              cpu_req;
  logic [SET_W-1:0]  cpu_set;
  logic              snp_req;
  logic [SET_W-1:0]  snp_set;
  logic              clr_req;
  logic              cpu_gnt;
  logic              snp_gnt;
  logic [1:0]        owner;
  logic              rd_valid;
  logic [LINE_W-1:0] rd_data;
  logic              wb_valid;
  logic              wb_we;
  logic [LINE_W-1:0] wb_data;
  logic              ram_en;
  logic              ram_we;
  logic [SET_W-1:0]  ram_addr;
  logic [LINE_W-1:0] ram_wdata;
  logic [LINE_W-1:0] ram_rdata;
  logic              clr_busy;
  logic              clr_done;

  tag_array_arbiter #(
    .SET_W(SET_W), .LINE_W(LINE_W), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_set(cpu_set),
    .snp_req(snp_req), .snp_set(snp_set),
    .clr_req(clr_req),
    .cpu_gnt(cpu_gnt), .snp_gnt(snp_gnt), .owner(owner),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_data(wb_data),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .clr_busy(clr_busy), .clr_done(clr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port synchronous tag array: read data appears the cycle after the access.
  logic [LINE_W-1:0] mem [NSETS];
  int                wr_count = 0;

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        mem[ram_addr] <= ram_wdata;
        wr_count      <= wr_count + 1;
      end else begin
        ram_rdata <= mem[ram_addr];
      end
    end
  end

  // Reference: what every set must contain, and the rule-level arbitration state.
  logic [LINE_W-1:0] ref_mem [NSETS];
  int                m_starve = 0;
  int                checks   = 0;
  int                errors   = 0;
  logic [1:0]        w;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LINE_W-1:0] rand_line;
    logic [127:0] v;
    v = {$urandom(), $urandom(), $urandom(), $urandom()};
    return v[LINE_W-1:0];
  endfunction

  // Winner by the arbitration rules: clear first, then snoop, unless a starved CPU is waiting.
  task automatic model_arb(output logic [1:0] win);
    bit cpu_starved;
`ifdef STARVE_GUARD_EN
    cpu_starved = (m_starve >= STARVE_MAX);
`else
    cpu_starved = 1'b0;
`endif
    if (clr_req)                               win = 2'd3;
    else if (snp_req && !(cpu_req && cpu_starved)) win = 2'd2;
    else if (cpu_req)                          win = 2'd1;
    else                                       win = 2'd0;
    if (win == 2'd1)                                  m_starve = 0;
    else if (win >= 2'd2 && cpu_req && m_starve < STARVE_MAX) m_starve++;
  endtask

  // Called in the cycle after a win; returns in the following IDLE cycle.
  task automatic run_txn(input logic [1:0] who, input int set, input int delay, input bit we,
                         input logic [LINE_W-1:0] data, input bit drop, input bit glitch);
    check("rd_cpu_gnt", cpu_gnt, who == 2'd1);
    check("rd_snp_gnt", snp_gnt, who == 2'd2);
    check("rd_owner", owner, who);
    check("rd_en_we", {ram_en, ram_we}, 2'b10);
    check("rd_addr", ram_addr, set);
    if (drop) begin
      if (who == 2'd1) cpu_req = 1'b0;
      else             snp_req = 1'b0;
    end
    if (glitch) begin
      wb_valid = 1'b1; wb_we = 1'b1; wb_data = '1;
    end
    tick;
    wb_valid = 1'b0;
    check("wait_en", ram_en, 1'b0);
    check("wait_gnt", {cpu_gnt, snp_gnt}, 2'b00);
    check("wait_rd_valid", rd_valid, 1'b0);
    tick;
    check("hold_rd_valid", rd_valid, 1'b1);
    check("hold_rd_data", rd_data, ref_mem[set]);
    for (int i = 0; i < delay; i++) begin
      tick;
      check("hold_wait_en", ram_en, 1'b0);
      check("hold_rd_pulse", rd_valid, 1'b0);
      check("hold_owner", owner, who);
    end
    wb_valid = 1'b1; wb_we = we; wb_data = data;
    tick;
    wb_valid = 1'b0; wb_we = 1'b0;
    check("wb_en_we", {ram_en, ram_we}, {we, we});
    if (we) begin
      check("wb_addr", ram_addr, set);
      check("wb_wdata", ram_wdata, data);
      ref_mem[set] = data;
    end
    tick;
    check("idle_owner", owner, 2'd0);
    check("idle_en", ram_en, 1'b0);
  endtask

  // Sweep from the IDLE cycle; abort_at < NSETS asserts rst while that address is presented.
  task automatic run_clr(input int abort_at);
    int w0;
    clr_req = 1'b1;
    tick;
    clr_req = 1'b0;
    w0 = wr_count;
    for (int i = 0; i < NSETS; i++) begin
      check("clr_addr", ram_addr, i);
      if (i == abort_at) begin
        rst = 1'b1;
        #1;
        check("rst_blocks_write", ram_en, 1'b0);
        tick;
        rst = 1'b0;
        m_starve = 0;
        check("rst_owner", owner, 2'd0);
        check("rst_busy", clr_busy, 1'b0);
        for (int k = 0; k < abort_at; k++) ref_mem[k] = '0;
        for (int k = 0; k < 20; k++) begin
          tick;
          check("abort_no_write", ram_en, 1'b0);
          check("abort_no_done", clr_done, 1'b0);
        end
        check("abort_writes", wr_count - w0, abort_at);
        return;
      end
      check("clr_en_we", {ram_en, ram_we}, 2'b11);
      check("clr_wdata", ram_wdata, 0);
      check("clr_busy", clr_busy, 1'b1);
      check("clr_owner", owner, 2'd3);
      check("clr_done_early", clr_done, 1'b0);
      tick;
    end
    check("clr_done", clr_done, 1'b1);
    check("clr_busy_end", clr_busy, 1'b0);
    check("clr_en_end", ram_en, 1'b0);
    check("clr_owner_end", owner, 2'd0);
    check("clr_writes", wr_count - w0, NSETS);
    for (int k = 0; k < NSETS; k++) ref_mem[k] = '0;
  endtask

  initial begin
    int mism;
    rst = 1'b1; cpu_req = 1'b0; cpu_set = '0; snp_req = 1'b0; snp_set = '0; clr_req = 1'b0;
    wb_valid = 1'b0; wb_we = 1'b0; wb_data = '0;
    repeat (3) tick;
    check("reset_owner", owner, 2'd0);
    check("reset_gnt", {cpu_gnt, snp_gnt}, 2'b00);
    check("reset_ram", {ram_en, ram_we}, 2'b00);
    check("reset_rd", {rd_valid, rd_data}, 0);
    check("reset_addr_wdata", {ram_addr, ram_wdata}, 0);
    check("reset_clr", {clr_busy, clr_done}, 2'b00);
    rst = 1'b0;
    tick;

    // Clear the whole array so the shadow image is known.
    run_clr(NSETS);
    tick;
    check("clr_done_pulse", clr_done, 1'b0);

    // Basic CPU read-modify-write on set 0x0012 (truncated to the bench's set width).
    cpu_req = 1'b1; cpu_set = 4'h2;
    model_arb(w);
    tick;
    run_txn(w, 2, 0, 1'b1, rand_line(), 1'b1, 1'b0);
    check("basic_winner", w, 2'd1);

    // Late write-back with no update.
    snp_req = 1'b1; snp_set = 4'h2;
    model_arb(w);
    tick;
    run_txn(w, 2, 10, 1'b0, rand_line(), 1'b1, 1'b0);

    // Stray write-back strobes in IDLE and RD.
    wb_valid = 1'b1; wb_we = 1'b1; wb_data = '1;
    repeat (2) begin
      tick;
      check("idle_wb_owner", owner, 2'd0);
      check("idle_wb_en", ram_en, 1'b0);
    end
    wb_valid = 1'b0; wb_we = 1'b0;
    cpu_req = 1'b1; cpu_set = 4'h6;
    model_arb(w);
    tick;
    run_txn(w, 6, 1, 1'b1, rand_line(), 1'b1, 1'b1);

    // Same-set collision: snoop first, CPU sees the snoop's update.
    cpu_req = 1'b1; cpu_set = 4'h5; snp_req = 1'b1; snp_set = 4'h5;
    model_arb(w);
    check("collide_first", w, 2'd2);
    tick;
    run_txn(w, 5, 0, 1'b1, rand_line(), 1'b1, 1'b0);
    check("collide_cpu_wait", cpu_gnt, 1'b0);
    model_arb(w);
    tick;
    run_txn(w, 5, 2, 1'b1, rand_line(), 1'b1, 1'b0);

    // Randomised single-requester traffic.
    for (int n = 0; n < 40; n++) begin
      int set;
      set = int'($urandom_range(NSETS - 1));
      if ($urandom_range(1) == 0) begin cpu_req = 1'b1; cpu_set = SET_W'(set); end
      else begin snp_req = 1'b1; snp_set = SET_W'(set); end
      model_arb(w);
      tick;
      run_txn(w, set, int'($urandom_range(3)), 1'($urandom_range(1)), rand_line(), 1'b1,
              1'($urandom_range(1)));
    end

    // Both paths held: grant order follows the rule model.
    cpu_req = 1'b1; cpu_set = 4'h7; snp_req = 1'b1; snp_set = 4'h9;
    for (int n = 0; n < 6; n++) begin
      model_arb(w);
      tick;
      run_txn(w, (w == 2'd1) ? 7 : 9, 0, 1'b1, rand_line(), 1'b0, 1'b0);
    end
    snp_req = 1'b0;
    model_arb(w);
    tick;
    run_txn(w, 7, 0, 1'b1, rand_line(), 1'b1, 1'b0);

    // Clear outranks a pending snoop, which then reads a zeroed set.
    snp_req = 1'b1; snp_set = 4'h3;
    run_clr(NSETS);
    model_arb(w);
    tick;
    check("post_clr_done_pulse", clr_done, 1'b0);
    run_txn(w, 3, 0, 1'b1, rand_line(), 1'b1, 1'b0);

    // Sweep aborted by reset at the fifth write; later sets keep their data.
    cpu_req = 1'b1; cpu_set = 4'h4;
    model_arb(w);
    tick;
    run_txn(w, 4, 0, 1'b1, rand_line(), 1'b1, 1'b0);
    run_clr(4);
    cpu_req = 1'b1; cpu_set = 4'h4;
    model_arb(w);
    tick;
    run_txn(w, 4, 0, 1'b0, rand_line(), 1'b1, 1'b0);
    run_clr(NSETS);
    tick;

    mism = 0;
    for (int k = 0; k < NSETS; k++) if (mem[k] !== ref_mem[k]) mism++;
    check("ram_image", mism, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
